// File: rtl/guess_pkg.sv
// Shared types, constants and helpers for the number-guessing round sequencer.
// State encoding is visible on the State output, so the enum values are fixed.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  localparam logic [6:0] BOUND_LO    = 7'd0;
  localparam logic [6:0] BOUND_HI    = 7'd99;
  localparam logic [6:0] TARGET_SPAN = 7'd98;

  // Fibonacci form of x^7 + x^6 + 1; maximal length, so a nonzero seed never reaches zero.
  function automatic logic [6:0] lfsr7_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // Folds an LFSR value (1..127) onto a target in 1..98.
  function automatic logic [6:0] fold_target(input logic [6:0] v);
    return ((v >= TARGET_SPAN) ? (v - TARGET_SPAN) : v) + 7'd1;
  endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary (0..99) to two BCD digits.
// Zero latency; no flow control.
module bin2bcd99 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (bin >= 7'(i * 10)) tens = 4'(i);
    end
    units = 4'(bin - 7'(tens) * 7'd10);
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the two-digit guessing game: target draw, window narrowing, tries, win/lose, beeper.
// Load edge at cycle n -> CHECK at n+1 -> results at n+2; Start overrides everything and re-arms every cycle it is high.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int         MAX_TRIES   = 7,
  parameter int         BEEP_CYCLES = 25000000,
  parameter logic [6:0] LFSR_SEED   = 7'h5A
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Load,
  input  logic [3:0] Guess_ten,
  input  logic [3:0] Guess_unit,
  output logic [3:0] Target_ten,
  output logic [3:0] Target_unit,
  output logic [3:0] Low_ten,
  output logic [3:0] Low_unit,
  output logic [3:0] High_ten,
  output logic [3:0] High_unit,
  output logic [3:0] Tries_left,
  output logic [2:0] State,
  output logic       Guess_err,
  output logic       Win,
  output logic       Lose,
  output logic       Beep
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);

  state_t        state, state_nxt;
  logic [6:0]    lfsr;
  logic [6:0]    target;
  logic [6:0]    low, high;
  logic [6:0]    guess_q;
  logic [3:0]    tries;
  logic          load_q;
  logic [BW-1:0] beep_cnt;

  logic       load_edge;
  logic [6:0] guess_bin;
  logic       digits_ok;
  logic       guess_ok;
  logic [3:0] tries_dec;
  logic       reject;

  assign load_edge = Load & ~load_q;
  assign guess_bin = 7'(Guess_ten) * 7'd10 + 7'(Guess_unit);
  assign digits_ok = (Guess_ten <= 4'd9) && (Guess_unit <= 4'd9);
  // Bounds are exclusive: the window shown is (Low, High).
  assign guess_ok  = digits_ok && (guess_bin > low) && (guess_bin < high);
  assign tries_dec = tries - 4'd1;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reject    = 1'b0;
    if (Start) begin
      state_nxt = ARM;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        ARM:   state_nxt = PLAY;
        PLAY: begin
          if (load_edge) begin
            if (guess_ok) state_nxt = CHECK;
            else          reject    = 1'b1;
          end
        end
        CHECK: begin
          if (guess_q == target)    state_nxt = WIN;
          else if (tries_dec == '0) state_nxt = LOSE;
          else                      state_nxt = PLAY;
        end
        WIN:     state_nxt = WIN;
        LOSE:    state_nxt = LOSE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr      <= LFSR_SEED;
      load_q    <= 1'b0;
      target    <= 7'd0;
      low       <= BOUND_LO;
      high      <= BOUND_HI;
      guess_q   <= 7'd0;
      tries     <= 4'(MAX_TRIES);
      Guess_err <= 1'b0;
      Win       <= 1'b0;
      Lose      <= 1'b0;
      Beep      <= 1'b0;
      beep_cnt  <= '0;
    end else begin
      lfsr      <= lfsr7_step(lfsr);
      load_q    <= Load;
      Guess_err <= reject;
      Win       <= (state_nxt == WIN);
      Lose      <= (state_nxt == LOSE);

      if (state == ARM) begin
        target <= fold_target(lfsr);
        low    <= BOUND_LO;
        high   <= BOUND_HI;
        tries  <= 4'(MAX_TRIES);
      end

      if (state == PLAY && state_nxt == CHECK) guess_q <= guess_bin;

      // A Start arriving during CHECK discards the pending result.
      if (state == CHECK && !Start && guess_q != target) begin
        if (guess_q < target) low  <= guess_q;
        else                  high <= guess_q;
        tries <= tries_dec;
      end

      if (state_nxt == WIN && state != WIN) begin
        Beep     <= 1'b1;
        beep_cnt <= BW'(BEEP_CYCLES - 1);
      end else if (state_nxt == WIN) begin
        if (beep_cnt != '0) beep_cnt <= beep_cnt - BW'(1);
        else                Beep     <= 1'b0;
      end else begin
        Beep     <= 1'b0;
        beep_cnt <= '0;
      end
    end
  end

  assign State      = state;
  assign Tries_left = tries;

  bin2bcd99 u_target_bcd (.bin(target), .tens(Target_ten), .units(Target_unit));
  bin2bcd99 u_low_bcd    (.bin(low),    .tens(Low_ten),    .units(Low_unit));
  bin2bcd99 u_high_bcd   (.bin(high),   .tens(High_ten),   .units(High_unit));

endmodule
